// File: rtl/cla_seq_adder_ctrl_if.sv
// Operand/result handshake bundle for cla_seq_adder_ctrl.
// The sub signal is present only when CLA_SEQ_SUB_EN is defined.
`timescale 1ns/1ps
interface cla_seq_adder_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = $clog2(NSLICE);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CLA_SEQ_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic [IW-1:0]    slice_idx;

    modport master (
        output in_valid, a, b, cin,
`ifdef CLA_SEQ_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy, slice_idx
    );

    modport slave (
        input  in_valid, a, b, cin,
`ifdef CLA_SEQ_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy, slice_idx
    );
endinterface

// File: rtl/cla_seq_adder_ctrl.sv
// Sequential WIDTH-bit adder: one SLICE-bit carry-lookahead slice per cycle, LSB slice first.
// Optional feature macro: CLA_SEQ_SUB_EN (adds subtract via the sub input).
`timescale 1ns/1ps
module cla_seq_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         c_msb,
    output logic         co
);
    logic [W-1:0] p, g;
    logic [W:0]   c;

    assign p    = a ^ b;
    assign g    = a & b;
    assign c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_la
        assign c[i+1] = g[i] | (p[i] & c[i]);
    end

    assign s     = p ^ c[W-1:0];
    assign c_msb = c[W-1];
    assign co    = c[W];
endmodule

module cla_seq_adder_ctrl #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    cla_seq_adder_ctrl_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = $clog2(NSLICE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic [SLICE-1:0] sl_a, sl_b, sl_s;
    logic             sl_cmsb, sl_co, sub_in;

    assign sl_a = a_q[idx_q*SLICE +: SLICE];
    assign sl_b = b_q[idx_q*SLICE +: SLICE];

    cla_seq_slice #(.W(SLICE)) u_slice (
        .a(sl_a), .b(sl_b), .ci(carry_q),
        .s(sl_s), .c_msb(sl_cmsb), .co(sl_co)
    );

`ifdef CLA_SEQ_SUB_EN
    assign sub_in = bus.sub;
`else
    assign sub_in = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        idx_d       = idx_q;
        unique case (state_q)
            IDLE: if (bus.in_valid) begin
                // Subtraction is a + ~b + 1, so cin is overridden rather than added.
                a_d     = bus.a;
                b_d     = sub_in ? ~bus.b : bus.b;
                carry_d = sub_in ? 1'b1 : bus.cin;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                sum_d[idx_q*SLICE +: SLICE] = sl_s;
                carry_d = sl_co;
                if (idx_q == IW'(NSLICE - 1)) begin
                    idx_d       = '0;
                    cout_d      = sl_co;
                    ovf_d       = sl_cmsb ^ sl_co;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: if (bus.out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            idx_q       <= idx_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.slice_idx = idx_q;
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed-vector bench for cla_seq_adder_ctrl (WIDTH=32, SLICE=4).
`timescale 1ns/1ps
module tb_cla_seq_adder_ctrl;
    localparam int WIDTH = 32;
    localparam int SLICE = 4;

    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    cla_seq_adder_ctrl_if #(.WIDTH(WIDTH), .SLICE(SLICE)) bus ();

    cla_seq_adder_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic sub);
        int t;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
`ifdef CLA_SEQ_SUB_EN
        bus.sub      = sub;
`else
        if (sub) $display("note: sub ignored in add-only build");
`endif
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; counts edges until out_valid.
    task automatic wait_result(output int lat, output bit idx_ok);
        lat    = 0;
        idx_ok = bus.busy;
        while (!bus.out_valid && lat < 20) begin
            if (bus.slice_idx != 3'(lat)) idx_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release_result(input int dly);
        repeat (dly) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [31:0] bb;
        logic        cc;
        logic [32:0] r;
        logic        ov;
        bb = sub ? ~b : b;
        cc = sub ? 1'b1 : cin;
        r  = {1'b0, a} + {1'b0, bb} + {32'd0, cc};
        ov = (a[31] == bb[31]) && (r[31] != a[31]);
        return {ov, r};
    endfunction

    initial begin
        int          lat;
        bit          ok;
        logic [33:0] m;
        logic [31:0] ra, rb;
        logic        rc, rs;

        vt[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vt[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vt[2] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};
        vt[3] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vt[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vt[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vt[6] = '{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vt[7] = '{32'hDEADBEEF, 32'h01234567, 1'b0, 32'hDFD10456, 1'b0, 1'b0};

        // Reset with in_valid already high
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = 32'd3;
        bus.b         = 32'd4;
        bus.cin       = 1'b0;
`ifdef CLA_SEQ_SUB_EN
        bus.sub       = 1'b0;
`endif
        bus.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sum", 64'(bus.sum), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_slice_idx", 64'(bus.slice_idx), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("first_edge_accept", 64'(bus.busy), 64'd1);
        wait_result(lat, ok);
        chk("first_lat", 64'(lat), 64'd8);
        chk("first_sum", 64'(bus.sum), 64'd7);
        release_result(0);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            start_op(vt[i].a, vt[i].b, vt[i].cin, 1'b0);
            wait_result(lat, ok);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd8);
            chk($sformatf("v%0d_slice_idx", i), 64'(ok), 64'd1);
            chk($sformatf("v%0d_sum", i), 64'(bus.sum), 64'(vt[i].sum));
            chk($sformatf("v%0d_cout", i), 64'(bus.cout), 64'(vt[i].cout));
            chk($sformatf("v%0d_ovf", i), 64'(bus.ovf), 64'(vt[i].ovf));
            release_result(i % 3);
            chk($sformatf("v%0d_done_clr", i), 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'b010);
        end

        // Back-pressure in DONE with junk on the input side
        start_op(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b0);
        wait_result(lat, ok);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.a        = $urandom;
            bus.b        = $urandom;
            @(posedge clk); #1;
            chk("hold_sum", 64'(bus.sum), 64'h00000000DFD10456);
            chk("hold_flags", 64'({bus.out_valid, bus.cout, bus.ovf, bus.in_ready}), 64'b1000);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("hold_exit", 64'({bus.out_valid, bus.in_ready}), 64'b01);

        // Async reset mid-RUN
        start_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        lat = 0;
        while (bus.slice_idx != 3'd3 && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("abort_reach_idx3", 64'(bus.slice_idx), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outputs", 64'({bus.out_valid, bus.busy, bus.cout, bus.ovf, bus.slice_idx}), 64'd0);
        chk("abort_sum", 64'(bus.sum), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        #3 rst_n = 1'b1;
        start_op(32'h12345678, 32'h11111111, 1'b1, 1'b0);
        wait_result(lat, ok);
        chk("after_abort_lat", 64'(lat), 64'd8);
        chk("after_abort_sum", 64'(bus.sum), 64'h000000002345678A);
        release_result(0);

`ifdef CLA_SEQ_SUB_EN
        start_op(32'd5, 32'd7, 1'b1, 1'b1);
        wait_result(lat, ok);
        chk("sub_sum", 64'(bus.sum), 64'h00000000FFFFFFFE);
        chk("sub_cout", 64'(bus.cout), 64'd0);
        release_result(0);
`endif

        // Random back-to-back operations against the behavioural reference
        for (int r = 0; r < 1000; r++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom);
`ifdef CLA_SEQ_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            m = model(ra, rb, rc, rs);
            start_op(ra, rb, rc, rs);
            wait_result(lat, ok);
            chk($sformatf("rnd%0d a=%h b=%h c=%b s=%b", r, ra, rb, rc, rs),
                64'({lat[4:0], bus.ovf, bus.cout, bus.sum}), 64'({5'd8, m}));
            release_result(int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
